// File: rtl/fp_mul_newton_pipe_if.sv
// Operand/result bundle for fp_mul_newton_pipe.
// master: the upstream 1.5-subtract stage side (drives ce, operands, valid).
// slave : the multiplier itself.
interface fp_mul_newton_pipe_if;
    logic        ce;
    logic        valid_in;
    logic [30:0] a;
    logic [30:0] b;
    logic [30:0] p;
    logic        valid_out;

    modport master (
        output ce,
        output valid_in,
        output a,
        output b,
        input  p,
        input  valid_out
    );

    modport slave (
        input  ce,
        input  valid_in,
        input  a,
        input  b,
        output p,
        output valid_out
    );
endinterface

// File: rtl/fp_mul_newton_pipe.sv
// fp_mul_newton_pipe: 3-stage sign-less single-precision multiplier that closes
// the Newton-Raphson inverse-square-root step (y1 = diff * y0).
// Operands/result are {exp[7:0], man[22:0]}; denormal inputs flush to zero,
// denormal outputs flush to zero.
// Optional feature: define FP_MUL_ROUND_EN for round-to-nearest-even in S3;
// otherwise the result is truncated. Latency is 3 ce-enabled edges either way.
module fp_mul_newton_pipe (
    input  logic                       clk,
    input  logic                       rst,   // asynchronous, active-low
    fp_mul_newton_pipe_if.slave        bus
);

`ifdef FP_MUL_ROUND_EN
    localparam bit ROUND_ON = 1'b1;
`else
    localparam bit ROUND_ON = 1'b0;
`endif

    localparam logic [30:0] QNAN = 31'h7FC00000;
    localparam logic [30:0] INF  = 31'h7F800000;

    // ---------------- S1: capture / classify ----------------
    logic               s1_valid_q, s1_valid_d;
    logic               s1_nan_q,   s1_nan_d;
    logic               s1_inf_q,   s1_inf_d;
    logic               s1_zero_q,  s1_zero_d;
    logic signed [9:0]  s1_exp_q,   s1_exp_d;
    logic [47:0]        s1_prod_q,  s1_prod_d;

    // ---------------- S2: normalize ----------------
    logic               s2_valid_q, s2_valid_d;
    logic               s2_nan_q,   s2_nan_d;
    logic               s2_inf_q,   s2_inf_d;
    logic               s2_zero_q,  s2_zero_d;
    logic signed [9:0]  s2_exp_q,   s2_exp_d;
    logic [22:0]        s2_frac_q,  s2_frac_d;
    logic               s2_guard_q, s2_guard_d;
    logic               s2_sticky_q, s2_sticky_d;

    // ---------------- S3: round / pack (output registers) ----------------
    logic               valid_out_q, valid_out_d;
    logic [30:0]        p_q,         p_d;

    logic [7:0]         ea, eb;
    logic [22:0]        ma, mb;
    logic               a_zero, a_inf, a_nan;
    logic               b_zero, b_inf, b_nan;

    logic               round_up;
    logic [23:0]        frac_sum;
    logic [22:0]        frac_fin;
    logic signed [9:0]  exp_fin;

    // S1 next state: operand classification, biased exponent sum, significand product
    always_comb begin
        ea = bus.a[30:23];
        ma = bus.a[22:0];
        eb = bus.b[30:23];
        mb = bus.b[22:0];

        a_zero = (ea == 8'h00);
        a_inf  = (ea == 8'hFF) && (ma == '0);
        a_nan  = (ea == 8'hFF) && (ma != '0);
        b_zero = (eb == 8'h00);
        b_inf  = (eb == 8'hFF) && (mb == '0);
        b_nan  = (eb == 8'hFF) && (mb != '0);

        s1_valid_d = bus.valid_in;
        s1_nan_d   = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        s1_inf_d   = a_inf | b_inf;
        s1_zero_d  = a_zero | b_zero;
        s1_exp_d   = signed'({2'b00, ea}) + signed'({2'b00, eb}) - 10'sd127;
        s1_prod_d  = {1'b1, ma} * {1'b1, mb};
    end

    // S1 register stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_nan_q   <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_prod_q  <= '0;
        end else if (bus.ce) begin
            s1_valid_q <= s1_valid_d;
            s1_nan_q   <= s1_nan_d;
            s1_inf_q   <= s1_inf_d;
            s1_zero_q  <= s1_zero_d;
            s1_exp_q   <= s1_exp_d;
            s1_prod_q  <= s1_prod_d;
        end
    end

    // S2 next state: normalize the product; only the 23 fraction bits are kept,
    // the hidden 1 is implicit from here on
    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_nan_d   = s1_nan_q;
        s2_inf_d   = s1_inf_q;
        s2_zero_d  = s1_zero_q;
        if (s1_prod_q[47]) begin
            s2_exp_d    = s1_exp_q + 10'sd1;
            s2_frac_d   = s1_prod_q[46:24];
            s2_guard_d  = s1_prod_q[23];
            s2_sticky_d = |s1_prod_q[22:0];
        end else begin
            s2_exp_d    = s1_exp_q;
            s2_frac_d   = s1_prod_q[45:23];
            s2_guard_d  = s1_prod_q[22];
            s2_sticky_d = |s1_prod_q[21:0];
        end
    end

    // S2 register stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_q  <= 1'b0;
            s2_nan_q    <= 1'b0;
            s2_inf_q    <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_exp_q    <= '0;
            s2_frac_q   <= '0;
            s2_guard_q  <= 1'b0;
            s2_sticky_q <= 1'b0;
        end else if (bus.ce) begin
            s2_valid_q  <= s2_valid_d;
            s2_nan_q    <= s2_nan_d;
            s2_inf_q    <= s2_inf_d;
            s2_zero_q   <= s2_zero_d;
            s2_exp_q    <= s2_exp_d;
            s2_frac_q   <= s2_frac_d;
            s2_guard_q  <= s2_guard_d;
            s2_sticky_q <= s2_sticky_d;
        end
    end

    // S3 next state: round (or truncate), then resolve specials and range by priority
    always_comb begin
        round_up = ROUND_ON & s2_guard_q & (s2_sticky_q | s2_frac_q[0]);
        frac_sum = {1'b0, s2_frac_q} + {23'd0, round_up};
        // a carry out of the fraction means the significand rolled to 2.0:
        // renormalize to 1.0 with the exponent bumped
        if (frac_sum[23]) begin
            frac_fin = '0;
            exp_fin  = s2_exp_q + 10'sd1;
        end else begin
            frac_fin = frac_sum[22:0];
            exp_fin  = s2_exp_q;
        end

        valid_out_d = s2_valid_q;
        if (s2_nan_q) begin
            p_d = QNAN;
        end else if (s2_inf_q) begin
            p_d = INF;
        end else if (s2_zero_q) begin
            p_d = '0;
        end else if (exp_fin >= 10'sd255) begin
            p_d = INF;
        end else if (exp_fin <= 10'sd0) begin
            p_d = '0;
        end else begin
            p_d = {exp_fin[7:0], frac_fin};
        end
    end

    // S3 output register stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_out_q <= 1'b0;
            p_q         <= '0;
        end else if (bus.ce) begin
            valid_out_q <= valid_out_d;
            p_q         <= p_d;
        end
    end

    assign bus.p         = p_q;
    assign bus.valid_out = valid_out_q;

endmodule

// File: tb/tb_fp_mul_newton_pipe.sv
// Scoreboard bench for fp_mul_newton_pipe: the driver pushes expected results
// when an operation is accepted, a monitor pops and compares on each output.
module tb_fp_mul_newton_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_mul_newton_pipe_if bus ();

    fp_mul_newton_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [30:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: exact real-valued product, scaled to a 24-bit significand,
    // then rounded by value (nearest-even) or truncated.
    function automatic logic [30:0] ref_mul(input logic [30:0] x, input logic [30:0] y);
        int ex, ey, n, e, qi;
        real r, s, q, frac;
        bit xz, yz, xi, yi, xn, yn;
        logic [31:0] ev;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        xz = (ex == 0);   yz = (ey == 0);
        xi = (ex == 255) && (x[22:0] == 0);
        yi = (ey == 255) && (y[22:0] == 0);
        xn = (ex == 255) && (x[22:0] != 0);
        yn = (ey == 255) && (y[22:0] != 0);
        if (xn || yn || (xi && yz) || (yi && xz)) return 31'h7FC00000;
        if (xi || yi) return 31'h7F800000;
        if (xz || yz) return 31'h00000000;
        r = (8388608.0 + real'(int'(x[22:0]))) * (8388608.0 + real'(int'(y[22:0])));
        s = r;
        n = 0;
        while (s >= 16777216.0) begin
            s = s / 2.0;
            n++;
        end
        q = $floor(s);
        frac = s - q;
`ifdef FP_MUL_ROUND_EN
        if (frac > 0.5 || (frac == 0.5 && ($rtoi(q) % 2) == 1)) q = q + 1.0;
`endif
        if (q >= 16777216.0) begin
            q = q / 2.0;
            n++;
        end
        e = n + ex + ey - 150;
        if (e >= 255) return 31'h7F800000;
        if (e <= 0) return 31'h00000000;
        qi = $rtoi(q);
        ev = e;
        return {ev[7:0], qi[22:0]};
    endfunction

    // One driver cycle: present inputs, record the expected result if accepted.
    task automatic step(input logic v, input logic c, input logic [30:0] x,
                        input logic [30:0] y, input logic [30:0] e);
        bus.valid_in = v;
        bus.ce       = c;
        bus.a        = x;
        bus.b        = y;
        if (v && c) exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        bus.valid_in = 1'b0;
        bus.ce       = 1'b1;
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
    endtask

    function automatic logic [30:0] rand_normal(input bit near);
        logic [7:0] e;
        logic [22:0] m;
        e = near ? 8'($urandom_range(90, 164)) : 8'($urandom_range(1, 254));
        m = 23'($urandom);
        return {e, m};
    endfunction

    // Monitor: compare each result that leaves the pipe on a ce-enabled edge
    initial begin
        logic ce_s, rst_s;
        logic [30:0] e;
        forever begin
            @(posedge clk);
            ce_s  = bus.ce;
            rst_s = rst;
            #1;
            if (rst_s && ce_s && bus.valid_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got p=%h with no pending result at %0t", bus.p, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {1'b0, bus.p}, {1'b0, e});
                end
            end
        end
    end

    initial begin
        logic [31:0] frozen;
        logic [30:0] x, y;
        logic v, c;

        rst = 1'b1;
        bus.ce = 1'b0;
        bus.valid_in = 1'b0;
        bus.a = '0;
        bus.b = '0;
        #2 rst = 1'b0;
        #1;
        check("reset_valid_out", {31'd0, bus.valid_out}, 0);
        check("reset_p", {1'b0, bus.p}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Directed products and specials
        step(1, 1, 31'h3FC00000, 31'h40000000, 31'h40400000);
`ifdef FP_MUL_ROUND_EN
        step(1, 1, 31'h3F800001, 31'h3FC00000, 31'h3FC00002);
`else
        step(1, 1, 31'h3F800001, 31'h3FC00000, 31'h3FC00001);
`endif
        step(1, 1, 31'h7F000000, 31'h7F000000, 31'h7F800000);
        step(1, 1, 31'h00800000, 31'h00800000, 31'h00000000);
        step(1, 1, 31'h00000000, 31'h3F800000, 31'h00000000);
        step(1, 1, 31'h7F800000, 31'h00000000, 31'h7FC00000);
        step(1, 1, 31'h7FC00001, 31'h3F800000, 31'h7FC00000);
        step(1, 1, 31'h7F800000, 31'h3F800000, 31'h7F800000);
        step(1, 1, 31'h3FFFFFFF, 31'h3F800001, ref_mul(31'h3FFFFFFF, 31'h3F800001));
        drain();

        // Reset mid-stream: in-flight work is discarded
        step(1, 1, 31'h3FC00000, 31'h40000000, 31'h40400000);
        step(1, 1, 31'h40000000, 31'h40000000, 31'h40800000);
        step(1, 1, 31'h3F800000, 31'h3F800000, 31'h3F800000);
        bus.valid_in = 1'b1;
        bus.a = 31'h40400000;
        bus.b = 31'h40400000;
        #2 rst = 1'b0;
        #1;
        check("midreset_valid_out", {31'd0, bus.valid_out}, 0);
        check("midreset_p", {1'b0, bus.p}, 0);
        exp_q.delete();
        bus.valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset_idle", {31'd0, bus.valid_out}, 0);
        end

        // Stall: output frozen while ce=0, queued ops complete in order afterwards
        step(1, 1, 31'h40000000, 31'h40400000, 31'h40C00000);
        step(1, 1, 31'h3FC00000, 31'h3FC00000, 31'h40100000);
        step(1, 1, 31'h40800000, 31'h3F000000, 31'h40000000);
        step(1, 1, 31'h41000000, 31'h3E800000, 31'h40000000);
        frozen = {bus.valid_out, bus.p};
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 31'h7F800000, 31'h00000000, 31'h0);
            check("stall_hold", {bus.valid_out, bus.p}, frozen);
        end
        step(1, 1, 31'h40400000, 31'h40400000, 31'h41100000);
        step(1, 1, 31'h3F800000, 31'h40A00000, 31'h40A00000);
        drain();

        // Random sweep of normal operands with occasional ce stalls and bubbles
        for (int i = 0; i < 10000; i++) begin
            x = rand_normal($urandom_range(0, 1) == 1);
            y = rand_normal($urandom_range(0, 1) == 1);
            c = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 7) != 0);
            step(v, c, x, y, ref_mul(x, y));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always ends on its own
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
